score_tracker: RTL

Player-answer scoring stage for the memory game. Sits between the player controls and the display controller, downstream of `number_mem`. It debounces the player-input key and hands each accepted guess to `number_mem` over a request/acknowledge handshake. It uses the returned hit flag to maintain correct/incorrect counts and a sequentially computed percent-correct value for the hex display.

---
 rtl/score_tracker.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/score_tracker.sv
// Player-answer scoring stage: debounces the enter key, queries number_mem for each
// guess and keeps correct/incorrect counts plus a sequentially divided percent score.
module score_tracker #(
  parameter int DEBOUNCE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enter_n,
  input  logic [9:0] sw,
  input  logic       round_clear,
  input  logic       check_ack,
  input  logic       exist,
  output logic       check_req,
  output logic [9:0] guess,
  output logic [6:0] correct_cnt,
  output logic [6:0] incorrect_cnt,
  output logic [6:0] percent,
  output logic       busy,
  output logic       score_valid
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, UPDATE, DIV, DONE} state_t;

  localparam logic [15:0] DB_FIRE = 16'(DEBOUNCE - 1);
  localparam logic [15:0] DB_HOLD = 16'(DEBOUNCE);

  state_t      state, state_nxt;
  logic        sync_p0, key_s;
  logic [15:0] db_cnt;
  logic        press;
  logic        hit;
  logic [13:0] dvd;
  logic [7:0]  dvs;
  logic [7:0]  rem;
  logic [3:0]  step;
  logic [6:0]  corr_nxt, inc_nxt;

  function automatic logic [6:0] sat_inc(input logic [6:0] v);
    return (v >= 7'd99) ? 7'd99 : v + 7'd1;
  endfunction

  // One restoring-division step: returns {remainder, dividend/quotient shift register}.
  function automatic logic [21:0] div_step(input logic [7:0] r, input logic [13:0] q,
                                           input logic [7:0] d);
    logic [8:0] trial;
    trial = {r, q[13]};
    if (trial >= {1'b0, d})
      return {8'(trial - {1'b0, d}), q[12:0], 1'b1};
    return {trial[7:0], q[12:0], 1'b0};
  endfunction

  // The counter parks at DEBOUNCE so a held key fires exactly once.
  assign press     = ~key_s && (db_cnt == DB_FIRE);
  assign check_req = (state == REQ);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (press) state_nxt = REQ;
      REQ:     state_nxt = WAIT;
      WAIT:    if (check_ack) state_nxt = UPDATE;
      UPDATE:  state_nxt = DIV;
      DIV:     if (step == 4'd13) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (round_clear) state_nxt = IDLE;
  end

  always_comb begin
    corr_nxt = hit ? sat_inc(correct_cnt) : correct_cnt;
    inc_nxt  = hit ? incorrect_cnt : sat_inc(incorrect_cnt);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Input synchroniser and debounce
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      key_s   <= 1'b1;
      db_cnt  <= '0;
    end else begin
      sync_p0 <= enter_n;
      key_s   <= sync_p0;
      if (key_s)                 db_cnt <= '0;
      else if (db_cnt != DB_HOLD) db_cnt <= db_cnt + 16'd1;
    end
  end

  // Score datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      guess         <= '0;
      hit           <= 1'b0;
      correct_cnt   <= '0;
      incorrect_cnt <= '0;
      percent       <= '0;
      dvd           <= '0;
      dvs           <= '0;
      rem           <= '0;
      step          <= '0;
      score_valid   <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      if (round_clear) begin
        correct_cnt   <= '0;
        incorrect_cnt <= '0;
        percent       <= '0;
      end else begin
        case (state)
          IDLE: if (press) guess <= sw;
          WAIT: if (check_ack) hit <= exist;
          UPDATE: begin
            correct_cnt   <= corr_nxt;
            incorrect_cnt <= inc_nxt;
            dvd           <= 14'(corr_nxt) * 14'd100;
            dvs           <= {1'b0, corr_nxt} + {1'b0, inc_nxt};
            rem           <= '0;
            step          <= '0;
          end
          DIV: begin
            {rem, dvd} <= div_step(rem, dvd, dvs);
            step       <= step + 4'd1;
          end
          DONE: begin
            percent     <= dvd[6:0];
            score_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
